// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: SYNC, LEN, payload, CSUM framing with a buffered drain.
// Optional inter-byte timeout is enabled with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_parser #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned TIMEOUT_CLKS = 3480
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   output logic       o_Valid,
   output logic [7:0] o_Data,
   output logic       o_Last,
   input  logic       i_Ready,
   output logic [4:0] o_Frame_Len,
   output logic       o_Err_Len,
   output logic       o_Err_Csum,
   output logic       o_Err_Ovr,
   output logic       o_Err_Timeout
);

   localparam int unsigned LEN_W     = 5;
   localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_LEN,
      S_GET_PAYLOAD,
      S_GET_CSUM,
      S_DRAIN
   } state_t;

   state_t           r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_wr_idx;
   logic [LEN_W-1:0] r_rd_idx;
   logic [7:0]       r_csum;
   logic [7:0]       r_buf [MAX_LEN];
   logic             r_valid;
   logic [7:0]       r_data;
   logic             r_last;
   logic [LEN_W-1:0] r_frame_len;
   logic             r_err_len;
   logic             r_err_csum;
   logic             r_err_ovr;

   logic             w_buf_we;
   logic [LEN_W-1:0] w_nxt_idx;
   logic             w_rx_active;

   assign w_buf_we    = !i_Reset && i_Rx_DV && (r_state == S_GET_PAYLOAD);
   assign w_nxt_idx   = r_rd_idx + LEN_W'(1);
   assign w_rx_active = (r_state == S_GET_LEN) || (r_state == S_GET_PAYLOAD) ||
                        (r_state == S_GET_CSUM);

   // Payload storage; contents survive reset, only the indices are cleared.
   always_ff @(posedge i_Clock) begin
      if (w_buf_we) begin
         r_buf[r_wr_idx[IDX_W-1:0]] <= i_Rx_Byte;
      end
   end

`ifdef UART_CMD_TIMEOUT_EN
   localparam int unsigned TO_W    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_err_timeout;
   logic            w_to_expire;

   assign w_to_expire = w_rx_active && !i_Rx_DV && (r_to_cnt == TO_LAST);

   // Idle-clock counter inside a frame; any received byte restarts it.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_to_cnt      <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         r_err_timeout <= w_to_expire;
         if (i_Rx_DV || !w_rx_active || w_to_expire) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
      end
   end

   assign o_Err_Timeout = r_err_timeout;
`else
   logic w_to_expire;
   logic w_unused_timeout;

   assign w_to_expire      = 1'b0;
   assign w_unused_timeout = ^32'(TIMEOUT_CLKS);
   assign o_Err_Timeout    = 1'b0;
`endif

   // Frame state machine with registered stream and error outputs.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_wr_idx    <= '0;
         r_rd_idx    <= '0;
         r_csum      <= '0;
         r_valid     <= 1'b0;
         r_data      <= 8'h00;
         r_last      <= 1'b0;
         r_frame_len <= '0;
         r_err_len   <= 1'b0;
         r_err_csum  <= 1'b0;
         r_err_ovr   <= 1'b0;
      end else begin
         r_err_len  <= 1'b0;
         r_err_csum <= 1'b0;
         r_err_ovr  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                  r_state <= S_GET_LEN;
               end
            end

            S_GET_LEN: begin
               if (i_Rx_DV) begin
                  if ((i_Rx_Byte == 8'h00) || (i_Rx_Byte > MAX_LEN_B)) begin
                     r_err_len <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     r_len    <= i_Rx_Byte[LEN_W-1:0];
                     r_csum   <= i_Rx_Byte;
                     r_wr_idx <= '0;
                     r_state  <= S_GET_PAYLOAD;
                  end
               end
            end

            S_GET_PAYLOAD: begin
               if (i_Rx_DV) begin
                  r_csum   <= r_csum + i_Rx_Byte;
                  r_wr_idx <= r_wr_idx + LEN_W'(1);
                  if (r_wr_idx == (r_len - LEN_W'(1))) begin
                     r_state <= S_GET_CSUM;
                  end
               end
            end

            S_GET_CSUM: begin
               if (i_Rx_DV) begin
                  if (i_Rx_Byte == r_csum) begin
                     r_state     <= S_DRAIN;
                     r_rd_idx    <= '0;
                     r_valid     <= 1'b1;
                     r_data      <= r_buf[0];
                     r_last      <= (r_len == LEN_W'(1));
                     r_frame_len <= r_len;
                  end else begin
                     r_err_csum <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end
            end

            S_DRAIN: begin
               // Bytes arriving while draining are dropped, never parsed.
               if (i_Rx_DV) begin
                  r_err_ovr <= 1'b1;
               end
               if (r_valid && i_Ready) begin
                  if (r_last) begin
                     r_state     <= S_IDLE;
                     r_valid     <= 1'b0;
                     r_data      <= 8'h00;
                     r_last      <= 1'b0;
                     r_frame_len <= '0;
                  end else begin
                     r_rd_idx <= w_nxt_idx;
                     r_data   <= r_buf[w_nxt_idx[IDX_W-1:0]];
                     r_last   <= (w_nxt_idx == (r_len - LEN_W'(1)));
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_to_expire) begin
            r_state <= S_IDLE;
         end
      end
   end

   assign o_Valid     = r_valid;
   assign o_Data      = r_data;
   assign o_Last      = r_last;
   assign o_Frame_Len = r_frame_len;
   assign o_Err_Len   = r_err_len;
   assign o_Err_Csum  = r_err_csum;
   assign o_Err_Ovr   = r_err_ovr;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (TIMEOUT_CLKS = 20).
module tb_uart_cmd_parser;

   logic       i_Clock = 1'b0;
   logic       i_Reset;
   logic       i_Rx_DV;
   logic [7:0] i_Rx_Byte;
   logic       i_Ready;
   logic       o_Valid;
   logic [7:0] o_Data;
   logic       o_Last;
   logic [4:0] o_Frame_Len;
   logic       o_Err_Len;
   logic       o_Err_Csum;
   logic       o_Err_Ovr;
   logic       o_Err_Timeout;

   int errors = 0;
   int checks = 0;

   int n_len = 0;
   int n_csum = 0;
   int n_ovr = 0;
   int n_to = 0;
   int n_valid = 0;

   uart_cmd_parser #(
      .SYNC_BYTE    (8'hA5),
      .MAX_LEN      (16),
      .TIMEOUT_CLKS (20)
   ) dut (
      .i_Clock       (i_Clock),
      .i_Reset       (i_Reset),
      .i_Rx_DV       (i_Rx_DV),
      .i_Rx_Byte     (i_Rx_Byte),
      .o_Valid       (o_Valid),
      .o_Data        (o_Data),
      .o_Last        (o_Last),
      .i_Ready       (i_Ready),
      .o_Frame_Len   (o_Frame_Len),
      .o_Err_Len     (o_Err_Len),
      .o_Err_Csum    (o_Err_Csum),
      .o_Err_Ovr     (o_Err_Ovr),
      .o_Err_Timeout (o_Err_Timeout)
   );

   always #5 i_Clock = ~i_Clock;

   // Pulse and valid-cycle tallies sampled mid-cycle.
   always @(negedge i_Clock) begin
      if (!i_Reset) begin
         n_len   = n_len   + int'(o_Err_Len);
         n_csum  = n_csum  + int'(o_Err_Csum);
         n_ovr   = n_ovr   + int'(o_Err_Ovr);
         n_to    = n_to    + int'(o_Err_Timeout);
         n_valid = n_valid + int'(o_Valid);
      end
   end

   task automatic tick();
      @(posedge i_Clock);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      i_Rx_DV   = 1'b1;
      i_Rx_Byte = b;
      tick();
      i_Rx_DV   = 1'b0;
      i_Rx_Byte = 8'h00;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                          input logic l, input logic [4:0] fl);
      chk({tag, ".valid"}, 32'(o_Valid), 32'(v));
      chk({tag, ".data"},  32'(o_Data),  32'(d));
      chk({tag, ".last"},  32'(o_Last),  32'(l));
      chk({tag, ".flen"},  32'(o_Frame_Len), 32'(fl));
   endtask

   int s_len, s_csum, s_ovr, s_to, s_valid;

   initial begin
      i_Reset   = 1'b1;
      i_Rx_DV   = 1'b0;
      i_Rx_Byte = 8'h00;
      i_Ready   = 1'b1;
      tick();
      tick();
      chk_out("reset", 1'b0, 8'h00, 1'b0, 5'd0);
      chk("reset.errs", 32'({o_Err_Len, o_Err_Csum, o_Err_Ovr, o_Err_Timeout}), 32'd0);
      i_Reset = 1'b0;
      tick();

      // Good 3-byte frame, consumer always ready
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
      chk("a.pre_csum_valid", 32'(o_Valid), 32'd0);
      send(8'h69);
      chk_out("a.b0", 1'b1, 8'h11, 1'b0, 5'd3);
      tick();
      chk_out("a.b1", 1'b1, 8'h22, 1'b0, 5'd3);
      tick();
      chk_out("a.b2", 1'b1, 8'h33, 1'b1, 5'd3);
      tick();
      chk_out("a.after", 1'b0, 8'h00, 1'b0, 5'd0);

      // Bad checksum, then a good frame
      s_csum = n_csum; s_valid = n_valid;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h6A);
      chk("b.csum_pulse", 32'(o_Err_Csum), 32'd1);
      tick();
      chk("b.csum_clear", 32'(o_Err_Csum), 32'd0);
      chk("b.csum_count", 32'(n_csum - s_csum), 32'd1);
      chk("b.no_valid", 32'(n_valid - s_valid), 32'd0);
      send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h05);
      chk_out("b.good0", 1'b1, 8'h01, 1'b0, 5'd2);
      tick();
      chk_out("b.good1", 1'b1, 8'h02, 1'b1, 5'd2);
      tick();
      chk("b.done", 32'(o_Valid), 32'd0);

      // Illegal lengths: 0 and 17
      s_len = n_len; s_valid = n_valid;
      send(8'h00); send(8'hA5); send(8'h00);
      chk("c.len0_pulse", 32'(o_Err_Len), 32'd1);
      send(8'hA5); send(8'h11);
      chk("c.len17_pulse", 32'(o_Err_Len), 32'd1);
      tick();
      chk("c.len_count", 32'(n_len - s_len), 32'd2);
      chk("c.no_valid", 32'(n_valid - s_valid), 32'd0);

      // Backpressure for 10 cycles with an overrun byte mid-drain
      s_ovr = n_ovr;
      i_Ready = 1'b0;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
      chk_out("d.hold0", 1'b1, 8'h11, 1'b0, 5'd3);
      tick(); tick();
      send(8'hA5);
      chk("d.ovr_pulse", 32'(o_Err_Ovr), 32'd1);
      chk("d.hold_data", 32'(o_Data), 32'h11);
      for (int i = 0; i < 6; i++) tick();
      chk("d.ovr_clear", 32'(o_Err_Ovr), 32'd0);
      chk_out("d.hold9", 1'b1, 8'h11, 1'b0, 5'd3);
      chk("d.ovr_count", 32'(n_ovr - s_ovr), 32'd1);
      i_Ready = 1'b1;
      tick();
      chk_out("d.b1", 1'b1, 8'h22, 1'b0, 5'd3);
      tick();
      chk_out("d.b2", 1'b1, 8'h33, 1'b1, 5'd3);
      tick();
      chk("d.done", 32'(o_Valid), 32'd0);
      s_len = n_len;
      send(8'h00);
      tick();
      chk("d.sync_not_started", 32'(n_len - s_len), 32'd0);

      // Silence inside a frame
      s_to = n_to;
      send(8'hA5); send(8'h02); send(8'h11);
`ifdef UART_CMD_TIMEOUT_EN
      for (int i = 0; i < 19; i++) tick();
      chk("e.to_early", 32'(o_Err_Timeout), 32'd0);
      tick();
      chk("e.to_pulse", 32'(o_Err_Timeout), 32'd1);
      tick();
      chk("e.to_count", 32'(n_to - s_to), 32'd1);
      send(8'h22); send(8'h35);
      chk("e.idle_after_to", 32'(o_Valid), 32'd0);
`else
      for (int i = 0; i < 40; i++) tick();
      chk("e.no_to", 32'(n_to - s_to), 32'd0);
      chk("e.to_tied", 32'(o_Err_Timeout), 32'd0);
      send(8'h22); send(8'h35);
      chk_out("e.b0", 1'b1, 8'h11, 1'b0, 5'd2);
      tick();
      chk_out("e.b1", 1'b1, 8'h22, 1'b1, 5'd2);
      tick();
      chk("e.done", 32'(o_Valid), 32'd0);
`endif

      // Reset mid-payload, then a 1-byte frame
      s_len = n_len; s_csum = n_csum; s_ovr = n_ovr; s_to = n_to;
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
      i_Reset = 1'b1;
      tick();
      chk_out("f.in_reset", 1'b0, 8'h00, 1'b0, 5'd0);
      i_Reset = 1'b0;
      tick();
      chk("f.no_err", 32'((n_len - s_len) + (n_csum - s_csum) + (n_ovr - s_ovr) + (n_to - s_to)), 32'd0);
      send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
      chk_out("f.b0", 1'b1, 8'h7F, 1'b1, 5'd1);
      tick();
      chk_out("f.done", 1'b0, 8'h00, 1'b0, 5'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 3480, allowed idle clocks between bytes inside a frame.
REQ-004 SHALL have port i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_Reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_Rx_DV  input  1  one-cycle strobe marking a received byte.
REQ-007 SHALL have port i_Rx_Byte  input  8  received byte, valid when i_Rx_DV=1.
REQ-008 SHALL have port o_Valid  output  1  payload byte available.
REQ-009 SHALL have port o_Data  output  8  payload byte.
REQ-010 SHALL have port o_Last  output  1  marks the final payload byte of a frame.
REQ-011 SHALL have port i_Ready  input  1  consumer accepts o_Data when o_Valid=1.
REQ-012 SHALL have port o_Frame_Len  output  5  LEN of the frame being drained.
REQ-013 SHALL have port o_Err_Len  output  1  one-cycle pulse: illegal LEN.
REQ-014 SHALL have port o_Err_Csum  output  1  one-cycle pulse: checksum mismatch.
REQ-015 SHALL have port o_Err_Ovr  output  1  one-cycle pulse: byte dropped during drain.
REQ-016 SHALL have port o_Err_Timeout  output  1  one-cycle pulse: inter-byte timeout.

Function
REQ-017 SHALL accept frames of the form SYNC_BYTE, LEN, LEN payload bytes, CSUM, where CSUM = (LEN + sum of payload bytes) mod 256.
REQ-018 SHALL implement states IDLE, GET_LEN, GET_PAYLOAD, GET_CSUM and DRAIN.
REQ-019 In IDLE, a byte equal to SYNC_BYTE SHALL move to GET_LEN; other bytes SHALL be ignored with no error.
REQ-020 In GET_LEN, LEN of 0 or greater than MAX_LEN SHALL pulse o_Err_Len and return to IDLE; a legal LEN SHALL be stored, seed the 8-bit checksum, and move to GET_PAYLOAD.
REQ-021 GET_PAYLOAD SHALL write each byte into an internal MAX_LEN x 8 buffer at index 0..LEN-1, add it to the checksum modulo 256, and move to GET_CSUM after byte LEN.
REQ-022 In GET_CSUM, a matching byte SHALL move to DRAIN; a mismatch SHALL pulse o_Err_Csum, discard the buffer and return to IDLE.
REQ-023 o_Valid SHALL rise in the cycle after the i_Rx_DV carrying a correct CSUM (latency 1 clock).
REQ-024 In DRAIN: o_Valid=1, o_Data=buf[rd_idx], o_Last=(rd_idx==LEN-1), o_Frame_Len=LEN.
REQ-025 A transfer SHALL occur only when o_Valid and i_Ready are both 1; rd_idx SHALL advance by 1 per transfer.
REQ-026 o_Data SHALL hold stable while o_Valid=1 and i_Ready=0.
REQ-027 The transfer with o_Last=1 SHALL return the block to IDLE, with o_Valid=0 in the next cycle.
REQ-028 Any i_Rx_DV during DRAIN SHALL drop the byte and pulse o_Err_Ovr in the following cycle; a SYNC_BYTE arriving then SHALL NOT start a frame.
REQ-029 Outside DRAIN, o_Valid, o_Last and o_Frame_Len SHALL be 0, and o_Data SHALL be 8'h00.
REQ-030 Error pulses SHALL be registered, SHALL last exactly 1 clock, and SHALL occur in the cycle after the causing event.

Reset
REQ-031 While i_Reset=1 on a clock edge, the state SHALL become IDLE, and rd_idx, the write index, the checksum and the timeout counter SHALL clear.
REQ-032 During reset, all outputs SHALL be 0 (o_Data=8'h00).
REQ-033 Buffer contents need not be cleared on reset.
REQ-034 Reset asserted mid-frame or mid-drain SHALL abandon the frame without any error pulse.
REQ-035 Reset SHALL have priority over a coincident i_Rx_DV.

Configuration
REQ-036 With macro UART_CMD_TIMEOUT_EN defined: a counter SHALL clear on every i_Rx_DV and count in GET_LEN, GET_PAYLOAD and GET_CSUM; on reaching TIMEOUT_CLKS-1 without a byte, the block SHALL pulse o_Err_Timeout and return to IDLE.
REQ-037 With UART_CMD_TIMEOUT_EN undefined: no counter SHALL exist, the block SHALL wait indefinitely for the next byte, and o_Err_Timeout SHALL be tied to 0.

Verification
REQ-038 Frame A5 03 11 22 33 69 with i_Ready=1 -> o_Valid 1 cycle after the CSUM strobe; o_Data 11,22,33 on consecutive cycles; o_Last only with 33; o_Frame_Len=3.
REQ-039 Frame A5 03 11 22 33 6A -> o_Err_Csum single pulse, o_Valid never asserted, next good frame accepted.
REQ-040 Bytes 00 A5 00, then A5 11 -> o_Err_Len pulses twice, no output.
REQ-041 Good 3-byte frame with i_Ready held 0 for 10 cycles, and byte A5 sent during drain -> o_Data stays 11, o_Err_Ovr pulses once, drain then completes normally.
REQ-042 Macro defined, TIMEOUT_CLKS=20, A5 02 11 then silence -> o_Err_Timeout pulses once after 20 clocks, state IDLE; macro undefined -> no pulse, and later 22 35 completes the frame.
REQ-043 i_Reset pulsed after byte 2 of a payload -> outputs 0, no error pulses, following frame A5 01 7F 80 drains 7F with o_Last=1.
